// File: rtl/pc_gen_btb.sv
// pc_gen_btb: fetch-PC generator with a direct-mapped branch target buffer.
//
// Each cycle the next fetch PC is chosen from one of these sources, in
// priority order: EX redirect, ID jump, BTB prediction, sequential (+4).
// The BTB is indexed by pc[IDX_W+1:2] and tagged with the remaining upper
// bits. Each entry holds a 2-bit saturating direction counter. The
// prediction for the current pc_o is combinational, so EX can check it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall_all_i         hold PC/source/jump flag, even over a redirect
//   stall_fetch_i       hold PC unless an EX redirect is present
//   ex_redirect_i/_pc_i EX-resolved corrected PC (highest normal priority)
//   id_jump_i/_pc_i     ID-stage unconditional jump destination
//   upd_*_i             BTB training from one resolved branch
//   pc_o                registered fetch PC
//   pc_src_o            0 seq/reset, 1 BTB, 2 ID jump, 3 EX redirect
//   jmp_o               pc_o came from an ID jump
//   pred_taken_o        BTB predicts the instruction at pc_o taken
//   pred_target_o       predicted target, 0 when not predicted taken
module pc_gen_btb #(
  parameter int              ADDR_W      = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_all_i,
  input  logic              stall_fetch_i,
  input  logic              ex_redirect_i,
  input  logic [ADDR_W-1:0] ex_redirect_pc_i,
  input  logic              id_jump_i,
  input  logic [ADDR_W-1:0] id_jump_pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [1:0]        pc_src_o,
  output logic              jmp_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_BTB = 2'd1;
  localparam logic [1:0] SRC_ID  = 2'd2;
  localparam logic [1:0] SRC_EX  = 2'd3;

  // ---------------------------------------------------------------------
  // PC state
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_src;
  logic              r_jmp;

  logic [ADDR_W-1:0] w_pc_next;
  logic [1:0]        w_src_next;
  logic              w_jmp_next;

  // ---------------------------------------------------------------------
  // BTB read view (one element per entry, driven from the generate block)
  // ---------------------------------------------------------------------
  logic              w_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  w_tag    [BTB_ENTRIES];
  logic [ADDR_W-1:0] w_target [BTB_ENTRIES];
  logic [1:0]        w_ctr    [BTB_ENTRIES];

  // Lookup on the current fetch PC
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_hit;
  logic              w_pred_taken;

  assign w_idx        = r_pc[IDX_W+1:2];
  assign w_lk_tag     = r_pc[ADDR_W-1:IDX_W+2];
  assign w_hit        = w_valid[w_idx] && (w_tag[w_idx] == w_lk_tag);
  assign w_pred_taken = w_hit && w_ctr[w_idx][1];

  assign pred_taken_o  = w_pred_taken;
  assign pred_target_o = w_pred_taken ? w_target[w_idx] : '0;

  // Training lookup: hit/miss is decided against pre-update contents, so a
  // same-cycle fetch lookup also sees the old entry.
  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;

  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign w_upd_hit = w_valid[w_upd_idx] && (w_tag[w_upd_idx] == w_upd_tag);

  // Byte-offset bits of instruction addresses carry no information here.
  logic w_unused;
  assign w_unused = &{1'b0, upd_pc_i[1:0]};

  // ---------------------------------------------------------------------
  // BTB entries
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      logic              r_valid;
      logic [TAG_W-1:0]  r_tag;
      logic [ADDR_W-1:0] r_target;
      logic [1:0]        r_ctr;
      logic              w_sel;

      assign w_sel = upd_valid_i && (w_upd_idx == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_ctr   <= 2'b00;
        end else if (w_sel) begin
          if (w_upd_hit) begin
            if (upd_taken_i) begin
              r_ctr    <= (r_ctr == 2'b11) ? r_ctr : r_ctr + 2'b01;
              r_target <= upd_target_i;
            end else begin
              r_ctr    <= (r_ctr == 2'b00) ? r_ctr : r_ctr - 2'b01;
            end
          end else if (upd_taken_i) begin
            // Allocate or replace an aliasing entry, starting weakly taken.
            r_valid  <= 1'b1;
            r_tag    <= w_upd_tag;
            r_target <= upd_target_i;
            r_ctr    <= 2'b10;
          end
        end
      end

      assign w_valid[gi]  = r_valid;
      assign w_tag[gi]    = r_tag;
      assign w_target[gi] = r_target;
      assign w_ctr[gi]    = r_ctr;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------
  always_comb begin
    w_pc_next  = r_pc;
    w_src_next = r_src;
    w_jmp_next = r_jmp;
    if (stall_all_i) begin
      // hold everything
    end else if (ex_redirect_i) begin
      w_pc_next  = ex_redirect_pc_i;
      w_src_next = SRC_EX;
      w_jmp_next = 1'b0;
    end else if (stall_fetch_i) begin
      // hold everything
    end else if (id_jump_i) begin
      w_pc_next  = id_jump_pc_i;
      w_src_next = SRC_ID;
      w_jmp_next = 1'b1;
    end else if (w_pred_taken) begin
      w_pc_next  = w_target[w_idx];
      w_src_next = SRC_BTB;
      w_jmp_next = 1'b0;
    end else begin
      w_pc_next  = r_pc + ADDR_W'(4);
      w_src_next = SRC_SEQ;
      w_jmp_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_src <= SRC_SEQ;
      r_jmp <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_src <= w_src_next;
      r_jmp <= w_jmp_next;
    end
  end

  assign pc_o     = r_pc;
  assign pc_src_o = r_src;
  assign jmp_o    = r_jmp;

endmodule

// File: tb/tb_pc_gen_btb.sv
// Testbench for pc_gen_btb (ADDR_W=32, BTB_ENTRIES=16, RESET_PC=0).
// A behavioural model (BTB as plain arrays indexed by (pc/4)%16, tag pc/64)
// predicts pc_o/pc_src_o/jmp_o and the lookup outputs each cycle.
module tb_pc_gen_btb;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_all_i, stall_fetch_i;
  logic        ex_redirect_i;
  logic [31:0] ex_redirect_pc_i;
  logic        id_jump_i;
  logic [31:0] id_jump_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic [31:0] pc_o;
  logic [1:0]  pc_src_o;
  logic        jmp_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_pc;
  logic [1:0]  m_src;
  logic        m_jmp;
  bit          mv   [N];
  int unsigned mtag [N];
  logic [31:0] mtgt [N];
  int          mctr [N];

  always #5 clk = ~clk;

  pc_gen_btb #(.ADDR_W(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .stall_all_i(stall_all_i), .stall_fetch_i(stall_fetch_i),
    .ex_redirect_i(ex_redirect_i), .ex_redirect_pc_i(ex_redirect_pc_i),
    .id_jump_i(id_jump_i), .id_jump_pc_i(id_jump_pc_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .pc_o(pc_o), .pc_src_o(pc_src_o), .jmp_o(jmp_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
  );

  function automatic logic m_pred_taken(logic [31:0] pc);
    int i;
    i = int'((pc / 4) % N);
    return mv[i] && (mtag[i] == pc / 64) && (mctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(logic [31:0] pc);
    return m_pred_taken(pc) ? mtgt[int'((pc / 4) % N)] : 32'h0;
  endfunction

  task automatic clear_inputs();
    stall_all_i = 0; stall_fetch_i = 0;
    ex_redirect_i = 0; ex_redirect_pc_i = 0;
    id_jump_i = 0; id_jump_pc_i = 0;
    upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs,
  // then let the DUT take the same edge and settle.
  task automatic step();
    logic pt;
    logic [31:0] ptgt;
    int ui;
    bit uhit;
    pt   = m_pred_taken(m_pc);
    ptgt = m_pred_target(m_pc);
    if (rst) begin
      m_pc = 32'h0; m_src = 0; m_jmp = 0;
      for (int i = 0; i < N; i++) begin mv[i] = 0; mctr[i] = 0; end
    end else begin
      if (stall_all_i) begin
      end else if (ex_redirect_i) begin
        m_pc = ex_redirect_pc_i; m_src = 3; m_jmp = 0;
      end else if (stall_fetch_i) begin
      end else if (id_jump_i) begin
        m_pc = id_jump_pc_i; m_src = 2; m_jmp = 1;
      end else if (pt) begin
        m_pc = ptgt; m_src = 1; m_jmp = 0;
      end else begin
        m_pc = m_pc + 32'd4; m_src = 0; m_jmp = 0;
      end
      if (upd_valid_i) begin
        ui   = int'((upd_pc_i / 4) % N);
        uhit = mv[ui] && (mtag[ui] == upd_pc_i / 64);
        if (uhit && upd_taken_i) begin
          mctr[ui] = (mctr[ui] < 3) ? mctr[ui] + 1 : 3;
          mtgt[ui] = upd_target_i;
        end else if (uhit) begin
          mctr[ui] = (mctr[ui] > 0) ? mctr[ui] - 1 : 0;
        end else if (upd_taken_i) begin
          mv[ui] = 1; mtag[ui] = upd_pc_i / 64; mtgt[ui] = upd_target_i; mctr[ui] = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    step(); step();
    total++;
    if (pc_o !== 32'h0 || pc_src_o !== 2'd0 || jmp_o !== 1'b0 || pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: pc=%h src=%0d jmp=%b pt=%b required pc=0 src=0 jmp=0 pt=0",
               pc_o, pc_src_o, jmp_o, pred_taken_o);
    end
    rst = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (pc_o !== 32'(4 * k) || pc_src_o !== 2'd0) begin
        bad++;
        $display("FAIL seq_step%0d: pc=%h src=%0d required pc=%h src=0", k, pc_o, pc_src_o, 32'(4 * k));
      end
    end
  endtask

  task automatic test_priority();
    ex_redirect_i = 1; ex_redirect_pc_i = 32'h100;
    id_jump_i = 1; id_jump_pc_i = 32'h200; stall_fetch_i = 1;
    step();
    total++;
    if (pc_o !== 32'h100 || pc_src_o !== 2'd3 || jmp_o !== 1'b0) begin
      bad++;
      $display("FAIL prio_redirect: pc=%h src=%0d jmp=%b required pc=100 src=3 jmp=0", pc_o, pc_src_o, jmp_o);
    end
    ex_redirect_pc_i = 32'h300; stall_all_i = 1;
    step();
    total++;
    if (pc_o !== 32'h100 || pc_src_o !== 2'd3) begin
      bad++;
      $display("FAIL prio_stall_all: pc=%h src=%0d required pc=100 src=3", pc_o, pc_src_o);
    end
    clear_inputs();
  endtask

  task automatic test_id_jump();
    id_jump_i = 1; id_jump_pc_i = 32'h80;
    step();
    total++;
    if (pc_o !== 32'h80 || jmp_o !== 1'b1 || pc_src_o !== 2'd2) begin
      bad++;
      $display("FAIL id_jump: pc=%h jmp=%b src=%0d required pc=80 jmp=1 src=2", pc_o, jmp_o, pc_src_o);
    end
    clear_inputs();
    step();
    total++;
    if (pc_o !== 32'h84 || jmp_o !== 1'b0 || pc_src_o !== 2'd0) begin
      bad++;
      $display("FAIL id_jump_after: pc=%h jmp=%b src=%0d required pc=84 jmp=0 src=0", pc_o, jmp_o, pc_src_o);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    clear_inputs();
    ex_redirect_i = 1; ex_redirect_pc_i = pc;
    step();
    clear_inputs();
  endtask

  task automatic test_btb_training();
    upd_valid_i = 1; upd_pc_i = 32'h40; upd_taken_i = 1; upd_target_i = 32'h400;
    step();
    redirect_to(32'h40);
    total++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h400) begin
      bad++;
      $display("FAIL btb_pred: pt=%b tgt=%h required pt=1 tgt=400", pred_taken_o, pred_target_o);
    end
    step();
    total++;
    if (pc_o !== 32'h400 || pc_src_o !== 2'd1) begin
      bad++;
      $display("FAIL btb_follow: pc=%h src=%0d required pc=400 src=1", pc_o, pc_src_o);
    end
    upd_valid_i = 1; upd_pc_i = 32'h40; upd_taken_i = 0;
    step(); step();
    redirect_to(32'h40);
    total++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h0) begin
      bad++;
      $display("FAIL btb_untrain: pt=%b tgt=%h required pt=0 tgt=0", pred_taken_o, pred_target_o);
    end
    step();
    total++;
    if (pc_o !== 32'h44 || pc_src_o !== 2'd0) begin
      bad++;
      $display("FAIL btb_untrain_seq: pc=%h src=%0d required pc=44 src=0", pc_o, pc_src_o);
    end
  endtask

  task automatic test_alias_saturation();
    // counter is 0 here: four taken updates must saturate at 3, not wrap
    upd_valid_i = 1; upd_pc_i = 32'h40; upd_taken_i = 1; upd_target_i = 32'h500;
    repeat (4) step();
    upd_taken_i = 0;  // 3 -> 2, still predicts taken
    step();
    redirect_to(32'h40);
    total++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h500) begin
      bad++;
      $display("FAIL saturate: pt=%b tgt=%h required pt=1 tgt=500", pred_taken_o, pred_target_o);
    end
    upd_valid_i = 1; upd_pc_i = 32'h440; upd_taken_i = 1; upd_target_i = 32'h800;
    step();
    redirect_to(32'h40);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL alias_evict: pt=%b required pt=0", pred_taken_o);
    end
    redirect_to(32'h440);
    total++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h800) begin
      bad++;
      $display("FAIL alias_new: pt=%b tgt=%h required pt=1 tgt=800", pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_wrap_same_cycle();
    redirect_to(32'hFFFF_FFFC);
    step();
    total++;
    if (pc_o !== 32'h0 || pc_src_o !== 2'd0) begin
      bad++;
      $display("FAIL wrap: pc=%h src=%0d required pc=0 src=0", pc_o, pc_src_o);
    end
    stall_fetch_i = 1;
    upd_valid_i = 1; upd_pc_i = 32'h0; upd_taken_i = 1; upd_target_i = 32'h123C;
    #1;
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_old: pt=%b required pt=0", pred_taken_o);
    end
    step();
    clear_inputs();
    #1;
    total++;
    if (pc_o !== 32'h0 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h123C) begin
      bad++;
      $display("FAIL same_cycle_new: pc=%h pt=%b tgt=%h required pc=0 pt=1 tgt=123c",
               pc_o, pred_taken_o, pred_target_o);
    end
    step();
    total++;
    if (pc_o !== 32'h123C || pc_src_o !== 2'd1) begin
      bad++;
      $display("FAIL same_cycle_follow: pc=%h src=%0d required pc=123c src=1", pc_o, pc_src_o);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      rst              = ($urandom_range(0, 59) == 0);
      stall_all_i      = ($urandom_range(0, 9) == 0);
      stall_fetch_i    = ($urandom_range(0, 7) == 0);
      ex_redirect_i    = ($urandom_range(0, 7) == 0);
      ex_redirect_pc_i = 32'($urandom_range(0, 63)) * 4;
      id_jump_i        = ($urandom_range(0, 7) == 0);
      id_jump_pc_i     = 32'($urandom_range(0, 63)) * 4;
      upd_valid_i      = ($urandom_range(0, 1) == 0);
      upd_pc_i         = 32'($urandom_range(0, 63)) * 4;
      upd_taken_i      = ($urandom_range(0, 2) != 0);
      upd_target_i     = 32'($urandom_range(0, 63)) * 4;
      step();
      total++;
      if (pc_o !== m_pc || pc_src_o !== m_src || jmp_o !== m_jmp ||
          pred_taken_o !== m_pred_taken(m_pc) || pred_target_o !== m_pred_target(m_pc)) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_c%0d: pc=%h src=%0d jmp=%b pt=%b tgt=%h required pc=%h src=%0d jmp=%b pt=%b tgt=%h",
                   c, pc_o, pc_src_o, jmp_o, pred_taken_o, pred_target_o,
                   m_pc, m_src, m_jmp, m_pred_taken(m_pc), m_pred_target(m_pc));
      end
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_id_jump();
    test_btb_training();
    test_alias_saturation();
    test_wrap_same_cycle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
